// File: rtl/lsu_mem_responder_pkg.sv
// mem_pkg: shared types and helpers for the LSU data-memory responder.
//   mem_size_e   access size encoding (B/H/W/D = 1/2/4/8 bytes)
//   mem_state_e  responder FSM states
//   size_to_mask byte-lane write mask for a size at a byte offset
//   is_misaligned natural-alignment check for a size at a byte offset
package mem_pkg;

  localparam int NUM_LANES = 8;   // byte lanes per 64-bit word
  localparam int LANE_W    = 8;

  typedef enum logic [1:0] {
    MEM_B = 2'd0,
    MEM_H = 2'd1,
    MEM_W = 2'd2,
    MEM_D = 2'd3
  } mem_size_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  // Lanes that fall off the top of the word are dropped; that only
  // happens for misaligned accesses, which never write.
  function automatic logic [NUM_LANES-1:0] size_to_mask(mem_size_e size, logic [2:0] off);
    logic [NUM_LANES-1:0] m;
    case (size)
      MEM_B:   m = 8'h01;
      MEM_H:   m = 8'h03;
      MEM_W:   m = 8'h0F;
      MEM_D:   m = 8'hFF;
      default: m = 8'h00;
    endcase
    return m << off;
  endfunction

  function automatic logic is_misaligned(mem_size_e size, logic [2:0] off);
    logic r;
    case (size)
      MEM_B:   r = 1'b0;
      MEM_H:   r = off[0];
      MEM_W:   r = |off[1:0];
      MEM_D:   r = |off;
      default: r = 1'b1;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/lsu_mem_responder_if.sv
// Request/response channel between the LSU (master) and the memory
// responder (slave). Signal names are from the responder's side.
//   i_req_valid/o_req_ready  request handshake
//   i_req_wen/addr/size/wdata request payload (wdata low-aligned)
//   o_rsp_valid/i_rsp_ready  response handshake
//   o_rsp_rdata/o_rsp_err    response payload (rdata low-aligned)
interface lsu_mem_responder_if;
  logic        i_req_valid;
  logic        o_req_ready;
  logic        i_req_wen;
  logic [63:0] i_req_addr;
  logic [1:0]  i_req_size;
  logic [63:0] i_req_wdata;
  logic        o_rsp_valid;
  logic        i_rsp_ready;
  logic [63:0] o_rsp_rdata;
  logic        o_rsp_err;

  modport slave (
    input  i_req_valid, i_req_wen, i_req_addr, i_req_size, i_req_wdata, i_rsp_ready,
    output o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );

  modport master (
    output i_req_valid, i_req_wen, i_req_addr, i_req_size, i_req_wdata, i_rsp_ready,
    input  o_req_ready, o_rsp_valid, o_rsp_rdata, o_rsp_err
  );
endinterface

// File: rtl/lsu_mem_responder_ram.sv
// mem_byte_ram: DEPTH x 64-bit array split into byte lanes.
//   i_clk    clock
//   i_we     per-lane write enable (synchronous write)
//   i_waddr  write word index
//   i_wdata  write data, already lane-aligned
//   i_raddr  read word index
//   o_rdata  combinational read data
// No reset: contents survive reset by design.
module mem_byte_ram
  import mem_pkg::*;
#(
  parameter int DEPTH = 1024,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic                               i_clk,
  input  logic [NUM_LANES-1:0]               i_we,
  input  logic [AW-1:0]                      i_waddr,
  input  logic [NUM_LANES-1:0][LANE_W-1:0]   i_wdata,
  input  logic [AW-1:0]                      i_raddr,
  output logic [NUM_LANES-1:0][LANE_W-1:0]   o_rdata
);

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    logic [LANE_W-1:0] r_mem [DEPTH];

    always_ff @(posedge i_clk) begin
      if (i_we[l]) r_mem[i_waddr] <= i_wdata[l];
    end

    assign o_rdata[l] = r_mem[i_raddr];
  end

endmodule

// File: rtl/lsu_mem_responder.sv
// lsu_mem_responder: synthesizable data memory serving LSU loads/stores.
//   i_clk  clock
//   i_rst  synchronous active-high reset (array contents kept)
//   bus    lsu_mem_responder_if.slave: one request at a time, response
//          LATENCY+1 cycles after accept, held until i_rsp_ready.
// Parameters: DEPTH words (power of two), LATENCY 0..15, BASE_ADDR of word 0.
module lsu_mem_responder
  import mem_pkg::*;
#(
  parameter int          DEPTH     = 1024,
  parameter int          LATENCY   = 1,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000
) (
  input  logic               i_clk,
  input  logic               i_rst,
  lsu_mem_responder_if.slave bus
);

  localparam int          IDX_W    = $clog2(DEPTH);
  localparam logic [63:0] SPAN     = 64'(DEPTH) << 3;
  localparam logic [3:0]  CNT_LOAD = 4'(LATENCY);

  if (LATENCY < 0 || LATENCY > 15) begin : g_bad_latency
    $error("lsu_mem_responder: LATENCY must be in 0..15");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("lsu_mem_responder: DEPTH must be a power of two >= 2");
  end

  mem_state_e  r_state, w_state_nxt;
  logic [3:0]  r_cnt, w_cnt_nxt;
  logic        r_wen;
  logic [63:0] r_addr;
  mem_size_e   r_size;
  logic [63:0] r_wdata;
  logic [63:0] r_rdata;
  logic        r_err;

  logic        w_accept, w_access;
  logic        w_a_wen;
  logic [63:0] w_a_addr, w_a_wdata, w_rel;
  mem_size_e   w_a_size;
  logic [2:0]  w_a_off;
  logic        w_err;
  logic [IDX_W-1:0] w_idx;
  logic [NUM_LANES-1:0] w_we;
  logic [63:0] w_wdata_sh, w_ram_rdata, w_rd_shift;

  assign bus.o_req_ready = (r_state == ST_IDLE) && !i_rst;
  assign bus.o_rsp_valid = (r_state == ST_RESP);
  assign bus.o_rsp_rdata = r_rdata;
  assign bus.o_rsp_err   = r_err;

  // With LATENCY==0 the access happens in the accept cycle, before the
  // request registers are loaded, so the live request is used in IDLE.
  assign w_a_wen   = (r_state == ST_IDLE) ? bus.i_req_wen               : r_wen;
  assign w_a_addr  = (r_state == ST_IDLE) ? bus.i_req_addr              : r_addr;
  assign w_a_size  = (r_state == ST_IDLE) ? mem_size_e'(bus.i_req_size) : r_size;
  assign w_a_wdata = (r_state == ST_IDLE) ? bus.i_req_wdata             : r_wdata;

  assign w_a_off = w_a_addr[2:0];
  assign w_rel   = w_a_addr - BASE_ADDR;
  // Below-base wraps w_rel high, but checking it explicitly keeps intent clear.
  assign w_err   = is_misaligned(w_a_size, w_a_off) || (w_a_addr < BASE_ADDR) || (w_rel >= SPAN);
  assign w_idx   = w_rel[IDX_W+2:3];

  assign w_wdata_sh = w_a_wdata << {w_a_off, 3'b000};
  assign w_rd_shift = w_ram_rdata >> {w_a_off, 3'b000};
  // Gating with i_rst drops a store whose commit edge is also the reset edge.
  assign w_we = {NUM_LANES{w_access && w_a_wen && !w_err && !i_rst}}
              & size_to_mask(w_a_size, w_a_off);

  mem_byte_ram #(.DEPTH(DEPTH)) u_ram (
    .i_clk   (i_clk),
    .i_we    (w_we),
    .i_waddr (w_idx),
    .i_wdata (w_wdata_sh),
    .i_raddr (w_idx),
    .o_rdata (w_ram_rdata)
  );

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_accept    = 1'b0;
    w_access    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (bus.i_req_valid && bus.o_req_ready) begin
          w_accept  = 1'b1;
          w_cnt_nxt = CNT_LOAD;
          if (LATENCY == 0) begin
            w_access    = 1'b1;
            w_state_nxt = ST_RESP;
          end else begin
            w_state_nxt = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (r_cnt == 4'd1) begin
          w_access    = 1'b1;
          w_cnt_nxt   = 4'd0;
          w_state_nxt = ST_RESP;
        end else begin
          w_cnt_nxt = r_cnt - 4'd1;
        end
      end
      ST_RESP: begin
        if (bus.i_rsp_ready) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state <= ST_IDLE;
      r_cnt   <= 4'd0;
      r_rdata <= 64'd0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      if (w_access) begin
        r_err   <= w_err;
        r_rdata <= (w_err || w_a_wen) ? 64'd0 : w_rd_shift;
      end
    end
  end

  // Request payload needs no reset: it is only read after an accept.
  always_ff @(posedge i_clk) begin
    if (w_accept) begin
      r_wen   <= bus.i_req_wen;
      r_addr  <= bus.i_req_addr;
      r_size  <= mem_size_e'(bus.i_req_size);
      r_wdata <= bus.i_req_wdata;
    end
  end

endmodule
